// File: rtl/ci_request_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ci_request_sequencer
// Description : Initiator side of the custom-instruction handshake. Pairs
//               float samples from a valid/ready stream into GO commands,
//               closes each block with READ, streams the returned result out
//               and then issues CLEAR to reset the responder.
// Revision    : 1.0 - initial release
// ============================================================================
module ci_request_sequencer #(
  parameter int FLT_DATA_WIDTH  = 32,
  parameter int N_WIDTH         = 2,
  parameter int PAIRS_PER_BLOCK = 8,
  parameter int TIMEOUT_CYCLES  = 1023,
  parameter int CNT_WIDTH       = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FLT_DATA_WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [FLT_DATA_WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      ci_clk_en,
  output logic                      ci_start,
  output logic [N_WIDTH-1:0]        ci_n,
  output logic [FLT_DATA_WIDTH-1:0] ci_dataa,
  output logic [FLT_DATA_WIDTH-1:0] ci_datab,
  input  logic [FLT_DATA_WIDTH-1:0] ci_result,
  input  logic                      ci_done
);

  // Command codes understood by the responder
  localparam logic [N_WIDTH-1:0] c_cmd_clear = N_WIDTH'(0);
  localparam logic [N_WIDTH-1:0] c_cmd_go    = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0] c_cmd_read  = N_WIDTH'(2);

  // Pair count that closes a block, and last wait-counter value before timeout
  localparam logic [CNT_WIDTH-1:0] c_pairs_max = CNT_WIDTH'(PAIRS_PER_BLOCK);
  localparam logic [CNT_WIDTH-1:0] c_tmo_last  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_COLLECT_A   = 4'd0,
    ST_COLLECT_B   = 4'd1,
    ST_ISSUE_GO    = 4'd2,
    ST_WAIT_GO     = 4'd3,
    ST_ISSUE_READ  = 4'd4,
    ST_WAIT_READ   = 4'd5,
    ST_PRESENT     = 4'd6,
    ST_ISSUE_CLEAR = 4'd7,
    ST_WAIT_CLEAR  = 4'd8,
    ST_ERROR       = 4'd9
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Registered datapath
  logic                      r_active;
  logic [FLT_DATA_WIDTH-1:0] r_dataa;
  logic [FLT_DATA_WIDTH-1:0] r_datab;
  logic [FLT_DATA_WIDTH-1:0] r_out_data;
  logic [N_WIDTH-1:0]        r_ci_n;
  logic [CNT_WIDTH-1:0]      r_pair_cnt;
  logic [CNT_WIDTH-1:0]      r_tmo_cnt;
  logic                      r_flush_pending;
  logic                      r_timeout_err;

  // Control strobes from the state machine into the datapath
  logic                 w_in_ready;
  logic                 w_start;
  logic                 w_out_valid;
  logic                 w_latch_a;
  logic                 w_latch_b;
  logic                 w_zero_b;
  logic                 w_go_done;
  logic                 w_read_done;
  logic                 w_clear_done;
  logic                 w_tmo_clr;
  logic                 w_tmo_inc;
  logic                 w_tmo_hit;
  logic                 w_tmo_expired;
  logic [CNT_WIDTH-1:0] w_pair_inc;

  assign w_pair_inc    = r_pair_cnt + CNT_WIDTH'(1);
  assign w_tmo_expired = (r_tmo_cnt == c_tmo_last);

  // State register; reset abandons any command in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_COLLECT_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_start      = 1'b0;
    w_out_valid  = 1'b0;
    w_latch_a    = 1'b0;
    w_latch_b    = 1'b0;
    w_zero_b     = 1'b0;
    w_go_done    = 1'b0;
    w_read_done  = 1'b0;
    w_clear_done = 1'b0;
    w_tmo_clr    = 1'b0;
    w_tmo_inc    = 1'b0;
    w_tmo_hit    = 1'b0;

    case (r_state)
      // Waiting for the first operand; a flush only matters if GOs are pending
      ST_COLLECT_A: begin
        if (r_active) begin
          w_in_ready = 1'b1;
          if (in_valid) begin
            w_latch_a   = 1'b1;
            w_state_nxt = ST_COLLECT_B;
          end else if (flush && (r_pair_cnt != '0)) begin
            w_state_nxt = ST_ISSUE_READ;
          end
        end
      end

      // Waiting for the second operand; a flush pads it with zero
      ST_COLLECT_B: begin
        if (r_active) begin
          w_in_ready = 1'b1;
          if (in_valid) begin
            w_latch_b   = 1'b1;
            w_state_nxt = ST_ISSUE_GO;
          end else if (flush) begin
            w_zero_b    = 1'b1;
            w_state_nxt = ST_ISSUE_GO;
          end
        end
      end

      ST_ISSUE_GO: begin
        w_start     = 1'b1;
        w_tmo_clr   = 1'b1;
        w_state_nxt = ST_WAIT_GO;
      end

      ST_WAIT_GO: begin
        w_tmo_inc = 1'b1;
        if (ci_done) begin
          w_go_done = 1'b1;
          if ((w_pair_inc == c_pairs_max) || r_flush_pending) begin
            w_state_nxt = ST_ISSUE_READ;
          end else begin
            w_state_nxt = ST_COLLECT_A;
          end
        end else if (w_tmo_expired) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_ERROR;
        end
      end

      ST_ISSUE_READ: begin
        w_start     = 1'b1;
        w_tmo_clr   = 1'b1;
        w_state_nxt = ST_WAIT_READ;
      end

      ST_WAIT_READ: begin
        w_tmo_inc = 1'b1;
        if (ci_done) begin
          w_read_done = 1'b1;
          w_state_nxt = ST_PRESENT;
        end else if (w_tmo_expired) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_ERROR;
        end
      end

      // Hold the result until downstream takes it; no commands meanwhile
      ST_PRESENT: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_ISSUE_CLEAR;
        end
      end

      ST_ISSUE_CLEAR: begin
        w_start     = 1'b1;
        w_tmo_clr   = 1'b1;
        w_state_nxt = ST_WAIT_CLEAR;
      end

      ST_WAIT_CLEAR: begin
        w_tmo_inc = 1'b1;
        if (ci_done) begin
          w_clear_done = 1'b1;
          w_state_nxt  = ST_COLLECT_A;
        end else if (w_tmo_expired) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_ERROR;
        end
      end

      // Responder is unresponsive; stay parked until reset
      ST_ERROR: begin
        w_state_nxt = ST_ERROR;
      end

      default: begin
        w_state_nxt = ST_ERROR;
      end
    endcase
  end

  // Clock-enable to the responder comes up on the first edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  // Operand capture; operands pass through untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dataa <= '0;
      r_datab <= '0;
    end else begin
      if (w_latch_a) begin
        r_dataa <= in_data;
      end
      if (w_latch_b) begin
        r_datab <= in_data;
      end else if (w_zero_b) begin
        r_datab <= '0;
      end
    end
  end

  // Command code is loaded on entry to an ISSUE state and held through WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ci_n <= c_cmd_clear;
    end else if (w_state_nxt != r_state) begin
      if (w_state_nxt == ST_ISSUE_GO) begin
        r_ci_n <= c_cmd_go;
      end else if (w_state_nxt == ST_ISSUE_READ) begin
        r_ci_n <= c_cmd_read;
      end else if (w_state_nxt == ST_ISSUE_CLEAR) begin
        r_ci_n <= c_cmd_clear;
      end
    end
  end

  // Block bookkeeping: completed pairs and a pending partial-block flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pair_cnt      <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      if (w_clear_done) begin
        r_pair_cnt      <= '0;
        r_flush_pending <= 1'b0;
      end else begin
        if (w_go_done) begin
          r_pair_cnt <= w_pair_inc;
        end
        if (w_zero_b) begin
          r_flush_pending <= 1'b1;
        end
      end
    end
  end

  // READ result capture, held for the output stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data <= '0;
    end else if (w_read_done) begin
      r_out_data <= ci_result;
    end
  end

  // Per-command wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_tmo_clr) begin
        r_tmo_cnt <= '0;
      end else if (w_tmo_inc) begin
        r_tmo_cnt <= r_tmo_cnt + CNT_WIDTH'(1);
      end
      if (w_tmo_hit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign out_data    = r_out_data;
  assign busy        = (r_state != ST_COLLECT_A);
  assign timeout_err = r_timeout_err;
  assign ci_clk_en   = r_active;
  assign ci_start    = w_start;
  assign ci_n        = r_ci_n;
  assign ci_dataa    = r_dataa;
  assign ci_datab    = r_datab;

endmodule
`default_nettype wire

// File: tb/tb_ci_request_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ci_request_sequencer
// Description : Self-checking bench for ci_request_sequencer with a
//               behavioural responder and command/result scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ci_request_sequencer;

  localparam int W   = 32;
  localparam int TMO = 1023;
  localparam int PPB = 8;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic [W-1:0]  in_data   = '0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic          flush     = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          timeout_err;
  logic          ci_clk_en;
  logic          ci_start;
  logic [1:0]    ci_n;
  logic [W-1:0]  ci_dataa;
  logic [W-1:0]  ci_datab;
  logic [W-1:0]  ci_result = '0;
  logic          ci_done   = 1'b0;

  ci_request_sequencer #(
    .FLT_DATA_WIDTH (W),
    .N_WIDTH        (2),
    .PAIRS_PER_BLOCK(PPB),
    .TIMEOUT_CYCLES (TMO),
    .CNT_WIDTH      (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .timeout_err(timeout_err),
    .ci_clk_en  (ci_clk_en),
    .ci_start   (ci_start),
    .ci_n       (ci_n),
    .ci_dataa   (ci_dataa),
    .ci_datab   (ci_datab),
    .ci_result  (ci_result),
    .ci_done    (ci_done)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   n;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;

  cmd_t         exp_cmd[$];
  logic [W-1:0] exp_out[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Responder configuration
  int           resp_delay     = 1;
  bit           resp_mute      = 1'b0;
  bit           stray_now      = 1'b0;
  bit           stray_on_start = 1'b0;
  logic [W-1:0] read_val       = '0;
  int           rd_done_cyc    = -100;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder: checks each command against the scoreboard, answers after resp_delay
  initial begin : p_resp
    cmd_t         e;
    int           pend;
    logic [1:0]   last_n;
    logic [W-1:0] last_a;
    logic [W-1:0] last_b;
    pend   = 0;
    last_n = 2'd0;
    last_a = '0;
    last_b = '0;
    forever begin
      @(negedge clk);
      ci_done = 1'b0;
      if (!rst) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ci_done = 1'b1;
          check_val("hold_n", 32'(ci_n), 32'(last_n));
          if (last_n == 2'd1) begin
            check_val("hold_dataa", ci_dataa, last_a);
            check_val("hold_datab", ci_datab, last_b);
          end
          if (last_n == 2'd2) begin
            ci_result   = read_val;
            rd_done_cyc = cyc;
          end else begin
            ci_result = 32'hA5A5_5A5A;
          end
        end
      end
      if (stray_now) begin
        ci_done   = 1'b1;
        ci_result = 32'h0BAD_0BAD;
        stray_now = 1'b0;
      end
      if (ci_start) begin
        if (exp_cmd.size() == 0) begin
          check_val("unexpected_start", 32'(ci_n), 32'hFFFF_FFFF);
        end else begin
          e = exp_cmd.pop_front();
          check_val("cmd_n", 32'(ci_n), 32'(e.n));
          if (e.n == 2'd1) begin
            check_val("go_dataa", ci_dataa, e.a);
            check_val("go_datab", ci_datab, e.b);
          end
        end
        last_n = ci_n;
        last_a = ci_dataa;
        last_b = ci_datab;
        if (stray_on_start) begin
          ci_done        = 1'b1;
          ci_result      = 32'h0BAD_0BAD;
          stray_on_start = 1'b0;
        end
        if (!resp_mute) pend = resp_delay;
      end
    end
  end

  task automatic push_cmd(input logic [1:0] n, input logic [W-1:0] a, input logic [W-1:0] b);
    cmd_t c;
    c.n = n;
    c.a = a;
    c.b = b;
    exp_cmd.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check_val(tag, 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    wait_ready("send_ready_tmo");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    push_cmd(2'd1, a, b);
    send(a);
    send(b);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_out_valid(input string tag);
    int k;
    logic [W-1:0] e;
    k = 0;
    while (!out_valid && k < 2000) begin
      tick();
      k++;
    end
    if (k >= 2000) begin
      check_val(tag, 32'(out_valid), 32'd1);
    end else begin
      check_val("out_latency", 32'(cyc - rd_done_cyc), 32'd1);
      e = (exp_out.size() != 0) ? exp_out.pop_front() : 32'hFFFF_FFFF;
      check_val("out_data", out_data, e);
    end
  endtask

  task automatic accept_out();
    int k;
    push_cmd(2'd0, '0, '0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("clear_start", 32'(ci_start), 32'd1);
    check_val("clear_n", 32'(ci_n), 32'd0);
    k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin : p_main
    int s_cyc;
    int k;
    int viol;
    logic [W-1:0] a;

    // ---------------- reset state ----------------
    #2 rst = 1'b0;
    #10;
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_clk_en", 32'(ci_clk_en), 32'd0);
    check_val("rst_start", 32'(ci_start), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_tmo_err", 32'(timeout_err), 32'd0);
    check_val("rst_out_data", out_data, 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    check_val("rel_in_ready", 32'(in_ready), 32'd1);
    check_val("rel_clk_en", 32'(ci_clk_en), 32'd1);

    // ---------------- full block ----------------
    resp_delay = 1;
    read_val   = 32'hDEAD_BEEF;
    exp_out.push_back(32'hDEAD_BEEF);
    for (int i = 0; i < PPB; i++) begin
      a = 32'h3F80_0000 + 32'(2 * i);
      if (i == PPB - 1) begin
        push_cmd(2'd1, a, a + 32'd1);
        push_cmd(2'd2, '0, '0);
        send(a);
        send(a + 32'd1);
      end else begin
        send_pair(a, a + 32'd1);
      end
      if (i == 0) begin
        check_val("go_start_t1", 32'(ci_start), 32'd1);
        check_val("go_n_t1", 32'(ci_n), 32'd1);
        tick();
        tick();
        check_val("collect_a_t3", 32'(in_ready), 32'd1);
        check_val("collect_a_busy", 32'(busy), 32'd0);
      end
    end
    wait_out_valid("full_out_tmo");
    accept_out();
    check_val("full_tmo_err", 32'(timeout_err), 32'd0);

    // ---------------- odd flush ----------------
    read_val = 32'h1234_5678;
    exp_out.push_back(32'h1234_5678);
    send_pair(32'h4000_0000, 32'h4040_0000);
    push_cmd(2'd1, 32'h4080_0000, 32'h0000_0000);
    push_cmd(2'd2, '0, '0);
    send(32'h4080_0000);
    pulse_flush();
    wait_out_valid("odd_out_tmo");
    accept_out();

    // ---------------- flush with nothing pending is ignored ----------------
    flush = 1'b1;
    tick();
    tick();
    tick();
    flush = 1'b0;
    check_val("flush_idle_busy", 32'(busy), 32'd0);

    // ---------------- stray done ----------------
    resp_delay = 2;
    read_val   = 32'h600D_F00D;
    exp_out.push_back(32'h600D_F00D);
    stray_now = 1'b1;
    tick();
    tick();
    check_val("stray_a_busy", 32'(busy), 32'd0);
    check_val("stray_a_ready", 32'(in_ready), 32'd1);
    stray_on_start = 1'b1;
    send_pair(32'h1111_1111, 32'h2222_2222);
    push_cmd(2'd2, '0, '0);
    tick();
    check_val("stray_go_pending", 32'(busy), 32'd1);
    wait_ready("stray_ready_tmo");
    pulse_flush();
    wait_out_valid("stray_out_tmo");
    accept_out();

    // ---------------- backpressure ----------------
    resp_delay = 1;
    read_val   = 32'hCAFE_F00D;
    exp_out.push_back(32'hCAFE_F00D);
    send_pair(32'h0000_0001, 32'h0000_0002);
    push_cmd(2'd2, '0, '0);
    tick();
    wait_ready("bp_ready_tmo");
    pulse_flush();
    wait_out_valid("bp_out_tmo");
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("bp_valid", 32'(out_valid), 32'd1);
      check_val("bp_data", out_data, 32'hCAFE_F00D);
    end
    accept_out();

    // ---------------- reset mid-command ----------------
    resp_delay = 10;
    send_pair(32'hAAAA_0001, 32'hAAAA_0002);
    tick();
    #2 rst = 1'b0;
    #1;
    check_val("mid_in_ready", 32'(in_ready), 32'd0);
    check_val("mid_out_valid", 32'(out_valid), 32'd0);
    check_val("mid_out_data", out_data, 32'd0);
    check_val("mid_busy", 32'(busy), 32'd0);
    check_val("mid_tmo_err", 32'(timeout_err), 32'd0);
    check_val("mid_clk_en", 32'(ci_clk_en), 32'd0);
    check_val("mid_start", 32'(ci_start), 32'd0);
    check_val("mid_n", 32'(ci_n), 32'd0);
    check_val("mid_dataa", ci_dataa, 32'd0);
    check_val("mid_datab", ci_datab, 32'd0);
    tick();
    #2 rst = 1'b1;
    tick();
    check_val("mid_rel_ready", 32'(in_ready), 32'd1);
    check_val("mid_rel_clk_en", 32'(ci_clk_en), 32'd1);
    resp_delay = 1;
    read_val   = 32'h0F0F_0F0F;
    exp_out.push_back(32'h0F0F_0F0F);
    send_pair(32'hBBBB_0001, 32'hBBBB_0002);
    push_cmd(2'd2, '0, '0);
    tick();
    wait_ready("mid_ready_tmo");
    pulse_flush();
    wait_out_valid("mid_out_tmo");
    accept_out();

    // ---------------- timeout ----------------
    resp_mute = 1'b1;
    push_cmd(2'd1, 32'h0000_0005, 32'h0000_0006);
    send(32'h0000_0005);
    send(32'h0000_0006);
    check_val("tmo_go_start", 32'(ci_start), 32'd1);
    s_cyc = cyc;
    k = 0;
    while (!timeout_err && k < TMO + 50) begin
      tick();
      k++;
    end
    check_val("tmo_latency", 32'(cyc - s_cyc), 32'(TMO + 1));
    check_val("tmo_err", 32'(timeout_err), 32'd1);
    viol     = 0;
    in_valid = 1'b1;
    in_data  = 32'h7777_7777;
    flush    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_ready || ci_start || !busy || !timeout_err) viol++;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    check_val("err_hold", 32'(viol), 32'd0);

    // ---------------- recovery by reset ----------------
    #2 rst = 1'b0;
    #1;
    check_val("rec_tmo_err", 32'(timeout_err), 32'd0);
    tick();
    #2 rst = 1'b1;
    resp_mute = 1'b0;
    tick();
    check_val("rec_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : p_watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
